// File: rtl/count_check_pkg.sv
// count_check_pkg: shared state encoding and default widths for the counter sequence checker.
package count_check_pkg;
    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_e;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = (inc && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    assign count = count_q;
endmodule

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: predicts counter+1 each valid sample, tracks lock and
// tallies mismatches and in-lock wraps.
module count_sequence_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_RUN = 2,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             mismatch,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] wrap_count
);
    localparam int RW = $clog2(LOCK_RUN + 1);
    state_e           state_q;
    logic [RW-1:0]    run_q;
    logic [RW-1:0]    run_d;
    logic [WIDTH-1:0] exp_q;
    logic             locked_q, mismatch_q;
    logic             hit, err_inc, wrap_inc;
    assign hit      = count_in == exp_q;
    assign run_d    = run_q + RW'(1);
    assign err_inc  = sample_en && state_q == LOCKED && !hit;
    // A correct 0 while locked is a wrap; a wrong 0 is only an error.
    assign wrap_inc = sample_en && state_q == LOCKED && hit && count_in == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q    <= SEEK;
            run_q      <= '0;
            exp_q      <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= err_inc;
            if (sample_en) begin
                exp_q <= count_in + WIDTH'(1);
                case (state_q)
                    SEEK: begin
                        run_q   <= '0;
                        state_q <= TRAIN;
                    end
                    TRAIN:
                        if (!hit) run_q <= '0;
                        else begin
                            run_q <= run_d;
                            if (run_d == RW'(LOCK_RUN)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    LOCKED:
                        if (!hit) begin
                            run_q    <= '0;
                            locked_q <= 1'b0;
                            state_q  <= TRAIN;
                        end
                    default: state_q <= SEEK;
                endcase
            end
        end
    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk(clk), .reset(reset), .inc(err_inc), .count(error_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_wrap (
        .clk(clk), .reset(reset), .inc(wrap_inc), .count(wrap_count)
    );
    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign expected = exp_q;
endmodule
